// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM states, funct3 width codes and request legality check.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   typedef logic [2:0] funct3_t;
   typedef logic [1:0] lane_t;

   localparam funct3_t F3_B  = 3'b000;
   localparam funct3_t F3_H  = 3'b001;
   localparam funct3_t F3_W  = 3'b010;
   localparam funct3_t F3_BU = 3'b100;
   localparam funct3_t F3_HU = 3'b101;

   // Illegal width code or misaligned address; such requests never touch memory.
   function automatic logic req_bad(logic we, funct3_t f3, lane_t lane);
      logic illegal;
      logic misal;
      if (we)
         illegal = !(f3 inside {F3_B, F3_H, F3_W});
      else
         illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      misal = ((f3 == F3_H || f3 == F3_HU) && lane[0])
            || (f3 == F3_W && lane != 2'b00);
      return illegal || misal;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and byte/halfword merge for stores.
// Little-endian: lane = address bits [1:0].
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rd_word,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_word
);

   logic [4:0]  sh;
   logic [15:0] half;
   logic [31:0] mask;

   always_comb begin
      sh   = {lane, 3'b000};
      half = 16'(rd_word >> sh);
      unique case (funct3)
         F3_B:    ld_data = {{24{half[7]}}, half[7:0]};
         F3_H:    ld_data = {{16{half[15]}}, half};
         F3_BU:   ld_data = {24'h0, half[7:0]};
         F3_HU:   ld_data = {16'h0, half};
         default: ld_data = rd_word;
      endcase
      mask    = (funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
      st_word = (mem_word & ~mask) | ((wdata << sh) & mask);
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request in flight, word-wide memory port.
// Sub-word stores are read-modify-write through RD then WR.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       write_data,
   input  logic [31:0]       read_data
);

   state_t            state_q, state_d;
   logic              we_q, we_d;
   funct3_t           f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [31:0]       ld_data;
   logic [31:0]       st_word;

   lsu_align u_align (
      .funct3   (f3_q),
      .lane     (addr_q[1:0]),
      .rd_word  (read_data),
      .mem_word (word_q),
      .wdata    (wdata_q),
      .ld_data  (ld_data),
      .st_word  (st_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Memory strobes decode from state_q alone, so async reset drops them at once.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      f3_d       = f3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      addr       = '0;
      write_data = '0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = req_bad(req_we, req_funct3, req_addr[1:0]);
               if (err_d)
                  state_d = RESP;
               else if (req_we && req_funct3 == F3_W)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            MemRead = 1'b1;
            addr    = {addr_q[ADDR_W-1:2], 2'b00};
            word_d  = read_data;
            if (we_q) begin
               state_d = WR;
            end else begin
               rdata_d = ld_data;
               state_d = RESP;
            end
         end
         WR: begin
            MemWrite   = 1'b1;
            addr       = {addr_q[ADDR_W-1:2], 2'b00};
            write_data = (f3_q == F3_W) ? wdata_q : st_word;
            state_d    = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
            if (resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
